codec_i2s_ctrl: RTL and testbench

Master clock/sequence controller for the codec I2S link. It holds the codec in reset for a power-up period, then generates BCLK and LRCLK from the 100 MHz system clock on start/stop commands. It also provides single-cycle clk-domain strobes (bclk_rise, bclk_fall, frame_start) so the i2s receiver and transmitter can sample and load without edge detection. It sits between the control logic and the codec pins, alongside the i2s receiver.

---
 rtl/codec_i2s_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_codec_i2s_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_i2s_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : codec_i2s_ctrl
// Description : Master clock and sequence controller for the codec I2S link.
//               After reset release it holds the codec in reset for a fixed
//               power-up period. It then generates BCLK and LRCLK from clk on
//               start/stop commands. It also produces single-cycle clk-domain
//               strobes so that neighbouring blocks need no edge detectors.
// Ports       : clk         - system clock; all logic on the rising edge
//               rst         - synchronous reset, active-low
//               start       - begin streaming; honoured only in IDLE
//               stop        - finish streaming at the next frame boundary
//               codec_rst_n - codec hardware reset, active-low
//               bclk        - bit clock
//               lrclk       - word select (0 = left, 1 = right)
//               bclk_rise   - first clk cycle in which bclk reads 1
//               bclk_fall   - first clk cycle in which bclk reads 0
//               frame_start - first cycle of each left slot
//               slot_bit    - bit index within the frame
//               busy        - streaming (RUN or DRAIN)
//               ready       - idle and able to accept start
// Revision    : 1.0 - initial release
// ============================================================================
module codec_i2s_ctrl #(
    parameter int BCLK_HALF  = 2,
    parameter int SLOT_BITS  = 32,
    parameter int RST_CYCLES = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            stop,
    output logic                            codec_rst_n,
    output logic                            bclk,
    output logic                            lrclk,
    output logic                            bclk_rise,
    output logic                            bclk_fall,
    output logic                            frame_start,
    output logic [$clog2(2*SLOT_BITS)-1:0]  slot_bit,
    output logic                            busy,
    output logic                            ready
);

    localparam int c_DIV_W  = (BCLK_HALF > 1)  ? $clog2(BCLK_HALF)  : 1;
    localparam int c_HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int c_SLOT_W = $clog2(2*SLOT_BITS);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(BCLK_HALF - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_CYCLES - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(2*SLOT_BITS - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_HALF = c_SLOT_W'(SLOT_BITS);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                r_state,     w_state;
    logic [c_HOLD_W-1:0]   r_hold_cnt,  w_hold_cnt;
    logic [c_DIV_W-1:0]    r_div,       w_div;
    logic [c_SLOT_W-1:0]   r_slot_bit,  w_slot_bit;
    logic [c_SLOT_W-1:0]   w_slot_inc;
    logic                  r_codec_rst_n, w_codec_rst_n;
    logic                  r_bclk,      w_bclk;
    logic                  r_lrclk,     w_lrclk;
    logic                  r_bclk_rise, w_bclk_rise;
    logic                  r_bclk_fall, w_bclk_fall;
    logic                  r_frame_start, w_frame_start;
    logic                  r_busy,      w_busy;
    logic                  r_ready,     w_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_div         <= '0;
            r_slot_bit    <= '0;
            r_codec_rst_n <= 1'b0;
            r_bclk        <= 1'b0;
            r_lrclk       <= 1'b0;
            r_bclk_rise   <= 1'b0;
            r_bclk_fall   <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_ready       <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_hold_cnt    <= w_hold_cnt;
            r_div         <= w_div;
            r_slot_bit    <= w_slot_bit;
            r_codec_rst_n <= w_codec_rst_n;
            r_bclk        <= w_bclk;
            r_lrclk       <= w_lrclk;
            r_bclk_rise   <= w_bclk_rise;
            r_bclk_fall   <= w_bclk_fall;
            r_frame_start <= w_frame_start;
            r_busy        <= w_busy;
            r_ready       <= w_ready;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_hold_cnt    = r_hold_cnt;
        w_div         = r_div;
        w_slot_bit    = r_slot_bit;
        w_slot_inc    = r_slot_bit + 1'b1;
        w_codec_rst_n = r_codec_rst_n;
        w_bclk        = r_bclk;
        w_lrclk       = r_lrclk;
        w_bclk_rise   = 1'b0;
        w_bclk_fall   = 1'b0;
        w_frame_start = 1'b0;

        case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state       = ST_IDLE;
                    w_codec_rst_n = 1'b1;
                end else begin
                    w_hold_cnt = r_hold_cnt + 1'b1;
                end
            end

            ST_IDLE: begin
                w_bclk     = 1'b0;
                w_lrclk    = 1'b0;
                w_slot_bit = '0;
                w_div      = '0;
                // A simultaneous stop cancels the start.
                if (start && !stop) begin
                    w_state       = ST_RUN;
                    w_frame_start = 1'b1;
                end
            end

            default: begin // ST_RUN, ST_DRAIN
                if (stop && (r_state == ST_RUN)) begin
                    w_state = ST_DRAIN;
                end
                if (r_div != c_DIV_LAST) begin
                    w_div = r_div + 1'b1;
                end else begin
                    w_div  = '0;
                    w_bclk = ~r_bclk;
                    if (!r_bclk) begin
                        w_bclk_rise = 1'b1;
                    end else begin
                        w_bclk_fall = 1'b1;
                        if (r_slot_bit == c_SLOT_LAST) begin
                            // Frame boundary: a drain ends here, otherwise
                            // a new left slot begins.
                            w_slot_bit = '0;
                            w_lrclk    = 1'b0;
                            if (r_state == ST_DRAIN) begin
                                w_state = ST_IDLE;
                            end else begin
                                w_frame_start = 1'b1;
                            end
                        end else begin
                            w_slot_bit = w_slot_inc;
                            w_lrclk    = (w_slot_inc >= c_SLOT_HALF);
                        end
                    end
                end
            end
        endcase

        w_busy  = (w_state == ST_RUN) || (w_state == ST_DRAIN);
        w_ready = (w_state == ST_IDLE);
    end

    assign codec_rst_n = r_codec_rst_n;
    assign bclk        = r_bclk;
    assign lrclk       = r_lrclk;
    assign bclk_rise   = r_bclk_rise;
    assign bclk_fall   = r_bclk_fall;
    assign frame_start = r_frame_start;
    assign slot_bit    = r_slot_bit;
    assign busy        = r_busy;
    assign ready       = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_codec_i2s_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_codec_i2s_ctrl
// Description : Self-checking bench for codec_i2s_ctrl. Expected outputs come
//               from an arithmetic model of the link timing as a function of
//               the number of clk edges since the start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_i2s_ctrl;

    localparam int BH      = 2;
    localparam int SB      = 32;
    localparam int RC      = 16;
    localparam int FRAME   = 2 * SB * 2 * BH;
    localparam int NO_STOP = 1 << 30;

    // Packed view: {codec_rst_n, bclk, lrclk, rise, fall, frame_start, busy, ready, slot_bit[5:0]}
    localparam logic [13:0] C_HOLD      = 14'b0_0_0_0_0_0_0_0_000000;
    localparam logic [13:0] C_IDLE      = 14'b1_0_0_0_0_0_0_1_000000;
    localparam logic [13:0] C_DRAIN_END = 14'b1_0_0_0_1_0_0_1_000000;

    logic       tb_bclk = 1'b0;
    logic       rst     = 1'b0;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       codec_rst_n, bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy, ready;
    logic [5:0] slot_bit;
    logic [13:0] obs;

    int n_pass  = 0;
    int n_total = 0;

    codec_i2s_ctrl #(
        .BCLK_HALF  (BH),
        .SLOT_BITS  (SB),
        .RST_CYCLES (RC)
    ) dut (
        .clk         (tb_bclk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .codec_rst_n (codec_rst_n),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .bclk_rise   (bclk_rise),
        .bclk_fall   (bclk_fall),
        .frame_start (frame_start),
        .slot_bit    (slot_bit),
        .busy        (busy),
        .ready       (ready)
    );

    always #5 tb_bclk = ~tb_bclk;

    assign obs = {codec_rst_n, bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy, ready, slot_bit};

    task automatic tick();
        @(posedge tb_bclk);
        #1;
    endtask

    // Expected outputs t edges after the start edge, with stop sampled at
    // edge ts (NO_STOP = never). Streaming ends at the first frame boundary
    // strictly after the stop edge.
    function automatic logic [13:0] exp_stream(input int t, input int ts);
        int   e;
        int   slot;
        int   half;
        logic b, r, f, fs;
        e = (ts >= NO_STOP) ? NO_STOP : (ts / FRAME + 1) * FRAME;
        if (t > e)  return C_IDLE;
        if (t == e) return C_DRAIN_END;
        half = t / BH;
        slot = (t / (2 * BH)) % (2 * SB);
        b    = (half % 2) == 1;
        r    = (t > 0) && (t % BH == 0) && b;
        f    = (t > 0) && (t % BH == 0) && !b;
        fs   = (t % FRAME) == 0;
        return {1'b1, b, (slot >= SB), r, f, fs, 1'b1, 1'b0, 6'(slot)};
    endfunction

    task automatic test_reset();
        int ps;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (obs !== C_HOLD) $display("FAIL reset_low i=%0d actual=%h expected=%h", i, obs, C_HOLD);
            else n_pass++;
        end
        rst = 1'b1;
        ps  = $urandom_range(1, RC);
        for (int i = 1; i <= RC; i++) begin
            start = (i == ps);
            tick();
            start = 1'b0;
            n_total++;
            if (obs !== ((i < RC) ? C_HOLD : C_IDLE))
                $display("FAIL reset_hold edge=%0d actual=%h expected=%h", i, obs, (i < RC) ? C_HOLD : C_IDLE);
            else n_pass++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++;
            if (obs !== C_IDLE) $display("FAIL hold_start_ignored i=%0d actual=%h expected=%h", i, obs, C_IDLE);
            else n_pass++;
        end
    endtask

    task automatic test_start_timing();
        int gap, ts, nr, nf, e;
        logic [13:0] x;
        nr  = 0;
        nf  = 0;
        gap = $urandom_range(1, 20);
        for (int i = 0; i < gap; i++) begin
            tick();
            n_total++;
            if (obs !== C_IDLE) $display("FAIL idle_wait i=%0d actual=%h expected=%h", i, obs, C_IDLE);
            else n_pass++;
        end
        ts = $urandom_range(300, 500);
        e  = (ts / FRAME + 1) * FRAME;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (obs !== exp_stream(0, ts)) $display("FAIL start_edge actual=%h expected=%h", obs, exp_stream(0, ts));
        else n_pass++;
        for (int t = 1; t <= e + 20; t++) begin
            stop  = (t == ts) ? 1'b1 : ((t > ts) ? 1'($urandom_range(0, 1)) : 1'b0);
            start = (t > ts && t <= e) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            x = exp_stream(t, ts);
            n_total++;
            if (obs !== x) $display("FAIL start_timing t=%0d actual=%h expected=%h", t, obs, x);
            else n_pass++;
            if (t <= FRAME && bclk_rise) nr++;
            if (t <= FRAME && bclk_fall) nf++;
        end
        start = 1'b0;
        stop  = 1'b0;
        n_total++;
        if (nr !== 2 * SB) $display("FAIL rise_count actual=%0d expected=%0d", nr, 2 * SB);
        else n_pass++;
        n_total++;
        if (nf !== 2 * SB) $display("FAIL fall_count actual=%0d expected=%0d", nf, 2 * SB);
        else n_pass++;
    endtask

    task automatic test_stop_drain();
        logic [13:0] x;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= FRAME + 30; t++) begin
            stop  = (t == 100) ? 1'b1 : ((t > 100) ? 1'($urandom_range(0, 1)) : 1'b0);
            start = (t > 100 && t <= FRAME) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            x = exp_stream(t, 100);
            n_total++;
            if (obs !== x) $display("FAIL stop_drain t=%0d actual=%h expected=%h", t, obs, x);
            else n_pass++;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_stop_boundary();
        logic [13:0] x;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 2 * FRAME + 10; t++) begin
            stop = (t == FRAME);
            tick();
            x = exp_stream(t, FRAME);
            n_total++;
            if (obs !== x) $display("FAIL stop_boundary t=%0d actual=%h expected=%h", t, obs, x);
            else n_pass++;
        end
        stop = 1'b0;
    endtask

    task automatic test_start_stop_idle();
        for (int i = 0; i < 300; i++) begin
            stop  = 1'b1;
            start = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            n_total++;
            if (obs !== C_IDLE) $display("FAIL start_stop_idle i=%0d actual=%h expected=%h", i, obs, C_IDLE);
            else n_pass++;
        end
        stop  = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int ts, e;
        logic [13:0] x;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t < 150; t++) begin
            tick();
            x = exp_stream(t, NO_STOP);
            n_total++;
            if (obs !== x) $display("FAIL pre_reset t=%0d actual=%h expected=%h", t, obs, x);
            else n_pass++;
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_total++;
        if (obs !== C_HOLD) $display("FAIL midframe_reset actual=%h expected=%h", obs, C_HOLD);
        else n_pass++;
        for (int i = 1; i <= RC; i++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            n_total++;
            if (obs !== ((i < RC) ? C_HOLD : C_IDLE))
                $display("FAIL rehold edge=%0d actual=%h expected=%h", i, obs, (i < RC) ? C_HOLD : C_IDLE);
            else n_pass++;
        end
        ts = $urandom_range(FRAME + 1, 2 * FRAME - 1);
        e  = (ts / FRAME + 1) * FRAME;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= e + 5; t++) begin
            stop = (t == ts);
            tick();
            x = exp_stream(t, ts);
            n_total++;
            if (obs !== x) $display("FAIL restart t=%0d actual=%h expected=%h", t, obs, x);
            else n_pass++;
        end
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        int gap, ts, e;
        logic [13:0] x;
        for (int s = 0; s < 3; s++) begin
            gap = $urandom_range(0, 4);
            for (int i = 0; i < gap; i++) begin
                tick();
                n_total++;
                if (obs !== C_IDLE) $display("FAIL b2b_gap s=%0d actual=%h expected=%h", s, obs, C_IDLE);
                else n_pass++;
            end
            ts = $urandom_range(1, 600);
            e  = (ts / FRAME + 1) * FRAME;
            start = 1'b1;
            tick();
            start = 1'b0;
            n_total++;
            if (obs !== exp_stream(0, ts)) $display("FAIL b2b_start s=%0d actual=%h expected=%h", s, obs, exp_stream(0, ts));
            else n_pass++;
            for (int t = 1; t <= e; t++) begin
                stop = (t == ts) ? 1'b1 : ((t > ts) ? 1'($urandom_range(0, 1)) : 1'b0);
                tick();
                x = exp_stream(t, ts);
                n_total++;
                if (obs !== x) $display("FAIL b2b s=%0d t=%0d actual=%h expected=%h", s, t, obs, x);
                else n_pass++;
            end
            stop = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_start_timing();
        test_stop_drain();
        test_stop_boundary();
        test_start_stop_idle();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
